// File: rtl/pea_cmd_decode.sv
`default_nettype none
// ============================================================================
//  Module   : pea_cmd_decode
//  Purpose  : Command-token front end of the Polynomial Evaluation
//             Accelerator. Pops command words from a first-word-fall-through
//             FIFO while the enable stage is in setup mode and decodes them
//             into mode / b / N / slot. Keeps a table of the degree N for up
//             to 8 coefficient vectors. Holds the decoded instruction until
//             the datapath signals completion.
//  Ports    :
//    clk            in   system clock, all state on rising edge
//    rst            in   synchronous active-high reset
//    enable         in   firing-ready flag from the enable stage
//    command_data   in   head word of the command FIFO (only [15:0] used)
//    fire_done      in   one-cycle pulse: current instruction finished
//    command_rd_en  out  pop strobe to the command FIFO
//    next_mode_out  out  2'b00 SETUP_INSTR, 2'b01 INSTR
//    mode           out  decoded opcode (0 STP, 1 EVP, 2 EVB, 3 RST)
//    b              out  second command argument
//    N              out  degree of the vector used by the current instruction
//    slot           out  coefficient-vector slot id
//    invalid_cmd    out  one-cycle pulse: popped token rejected
//  Revision : 1.0  initial release
// ============================================================================
module pea_cmd_decode #(
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [WORD_SIZE-1:0] command_data,
   input  logic                 fire_done,
   output logic                 command_rd_en,
   output logic [1:0]           next_mode_out,
   output logic [7:0]           mode,
   output logic [4:0]           b,
   output logic [3:0]           N,
   output logic [2:0]           slot,
   output logic                 invalid_cmd
);

   typedef enum logic [0:0] {
      ST_SETUP = 1'b0,
      ST_INSTR = 1'b1
   } state_t;

   localparam logic [7:0] c_OP_STP = 8'd0;
   localparam logic [7:0] c_OP_EVP = 8'd1;
   localparam logic [7:0] c_OP_EVB = 8'd2;
   localparam logic [7:0] c_OP_RST = 8'd3;

   localparam logic [1:0] c_NM_SETUP = 2'b00;
   localparam logic [1:0] c_NM_INSTR = 2'b01;

   // Registered state
   state_t     r_state_q;
   logic [7:0] r_mode_q;
   logic [4:0] r_b_q;
   logic [3:0] r_n_q;
   logic [2:0] r_slot_q;
   logic       r_invalid_q;
   logic [3:0] r_tbl_q [8];
   logic [7:0] r_valid_q;

   // Next-state values
   state_t     w_state_d;
   logic [7:0] w_mode_d;
   logic [4:0] w_b_d;
   logic [3:0] w_n_d;
   logic [2:0] w_slot_d;
   logic       w_invalid_d;
   logic [3:0] w_tbl_d [8];
   logic [7:0] w_valid_d;

   // Token fields
   logic [7:0] w_opcode;
   logic [4:0] w_arg_b;
   logic [2:0] w_arg_slot;
   logic       w_rd_en;
   logic       w_accept;

   assign w_opcode   = command_data[7:0];
   assign w_arg_b    = command_data[12:8];
   assign w_arg_slot = command_data[15:13];

   // Gating with rst keeps the FIFO from losing a word in a reset cycle.
   assign w_rd_en = (r_state_q == ST_SETUP) && enable && !rst;

   always_comb begin
      w_state_d   = r_state_q;
      w_mode_d    = r_mode_q;
      w_b_d       = r_b_q;
      w_n_d       = r_n_q;
      w_slot_d    = r_slot_q;
      w_invalid_d = 1'b0;
      w_tbl_d     = r_tbl_q;
      w_valid_d   = r_valid_q;
      w_accept    = 1'b0;

      case (r_state_q)
         ST_SETUP: begin
            if (w_rd_en) begin
               case (w_opcode)
                  c_OP_STP: begin
                     // Degree is 4 bits; b[4] set would overflow the table.
                     if (!w_arg_b[4]) begin
                        w_accept              = 1'b1;
                        w_n_d                 = w_arg_b[3:0];
                        w_tbl_d[w_arg_slot]   = w_arg_b[3:0];
                        w_valid_d[w_arg_slot] = 1'b1;
                     end
                  end
                  c_OP_EVP, c_OP_EVB: begin
                     // Table read uses the pre-edge contents, so a STP
                     // committed on an earlier edge is already visible.
                     if ((w_arg_b != 5'd0) && r_valid_q[w_arg_slot]) begin
                        w_accept = 1'b1;
                        w_n_d    = r_tbl_q[w_arg_slot];
                     end
                  end
                  c_OP_RST: begin
                     w_accept  = 1'b1;
                     w_n_d     = 4'd0;
                     w_valid_d = 8'd0;
                     for (int i = 0; i < 8; i++) begin
                        w_tbl_d[i] = 4'd0;
                     end
                  end
                  default: begin
                     w_accept = 1'b0;
                  end
               endcase

               if (w_accept) begin
                  w_mode_d  = w_opcode;
                  w_b_d     = w_arg_b;
                  w_slot_d  = w_arg_slot;
                  w_state_d = ST_INSTR;
               end else begin
                  // Rejected token: consumed, decoded outputs untouched.
                  w_invalid_d = 1'b1;
               end
            end
         end

         ST_INSTR: begin
            if (fire_done) begin
               w_state_d = ST_SETUP;
            end
         end

         default: begin
            w_state_d = ST_SETUP;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q   <= ST_SETUP;
         r_mode_q    <= 8'd0;
         r_b_q       <= 5'd0;
         r_n_q       <= 4'd0;
         r_slot_q    <= 3'd0;
         r_invalid_q <= 1'b0;
         r_valid_q   <= 8'd0;
         for (int i = 0; i < 8; i++) begin
            r_tbl_q[i] <= 4'd0;
         end
      end else begin
         r_state_q   <= w_state_d;
         r_mode_q    <= w_mode_d;
         r_b_q       <= w_b_d;
         r_n_q       <= w_n_d;
         r_slot_q    <= w_slot_d;
         r_invalid_q <= w_invalid_d;
         r_valid_q   <= w_valid_d;
         for (int i = 0; i < 8; i++) begin
            r_tbl_q[i] <= w_tbl_d[i];
         end
      end
   end

   assign command_rd_en = w_rd_en;
   assign next_mode_out = (r_state_q == ST_INSTR) ? c_NM_INSTR : c_NM_SETUP;
   assign mode          = r_mode_q;
   assign b             = r_b_q;
   assign N             = r_n_q;
   assign slot          = r_slot_q;
   assign invalid_cmd   = r_invalid_q;

endmodule
`default_nettype wire

// File: tb/tb_pea_cmd_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pea_cmd_decode
//  Purpose  : Self-checking bench for pea_cmd_decode. Stimulus pushes the
//             hand-computed decode result of every token into a scoreboard;
//             a monitor pops and compares whenever the DUT pops the FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pea_cmd_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] command_data;
   logic        fire_done;
   logic        command_rd_en;
   logic [1:0]  next_mode_out;
   logic [7:0]  mode;
   logic [4:0]  b;
   logic [3:0]  N;
   logic [2:0]  slot;
   logic        invalid_cmd;

   always #5 clk = ~clk;

   pea_cmd_decode #(.WORD_SIZE(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .command_data  (command_data),
      .fire_done     (fire_done),
      .command_rd_en (command_rd_en),
      .next_mode_out (next_mode_out),
      .mode          (mode),
      .b             (b),
      .N             (N),
      .slot          (slot),
      .invalid_cmd   (invalid_cmd)
   );

   typedef struct packed {
      logic       inv;
      logic [7:0] mode;
      logic [4:0] b;
      logic [3:0] n;
      logic [2:0] slot;
   } exp_t;

   exp_t sb_q [$];
   int   total = 0;
   int   bad   = 0;
   logic pop_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: a pop on an edge means the decode result is visible by the
   // following negedge.
   always @(posedge clk) pop_seen <= command_rd_en;

   always @(negedge clk) begin
      if (pop_seen) begin
         if (sb_q.size() == 0) begin
            check("unexpected_pop", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("invalid_cmd", {31'd0, invalid_cmd}, {31'd0, e.inv});
            check("next_mode", {30'd0, next_mode_out}, e.inv ? 32'd0 : 32'd1);
            check("mode", {24'd0, mode}, {24'd0, e.mode});
            check("b", {27'd0, b}, {27'd0, e.b});
            check("N", {28'd0, N}, {28'd0, e.n});
            check("slot", {29'd0, slot}, {29'd0, e.slot});
         end
      end
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic send(input logic [15:0] d, input logic inv, input logic [7:0] m,
                       input logic [4:0] bb, input logic [3:0] n, input logic [2:0] s);
      exp_t e;
      e.inv = inv; e.mode = m; e.b = bb; e.n = n; e.slot = s;
      sb_q.push_back(e);
      command_data = d;
      enable       = 1'b1;
      @(negedge clk);
      check("rd_en_on_send", {31'd0, command_rd_en}, 32'd1);
      @(posedge clk); #1;
      enable = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("invalid_pulse_width", {31'd0, invalid_cmd}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic finish_instr();
      for (int i = 0; i < 4; i++) begin
         enable = i[0];
         @(negedge clk);
         check("rd_en_in_instr", {31'd0, command_rd_en}, 32'd0);
         check("next_mode_in_instr", {30'd0, next_mode_out}, 32'd1);
         @(posedge clk); #1;
      end
      enable    = 1'b0;
      fire_done = 1'b1;
      @(posedge clk); #1;
      fire_done = 1'b0;
      @(negedge clk);
      check("next_mode_after_done", {30'd0, next_mode_out}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_next_mode"}, {30'd0, next_mode_out}, 32'd0);
      check({tag, "_mode"}, {24'd0, mode}, 32'd0);
      check({tag, "_b"}, {27'd0, b}, 32'd0);
      check({tag, "_N"}, {28'd0, N}, 32'd0);
      check({tag, "_slot"}, {29'd0, slot}, 32'd0);
      check({tag, "_invalid"}, {31'd0, invalid_cmd}, 32'd0);
      check({tag, "_rd_en"}, {31'd0, command_rd_en}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      enable       = 1'b0;
      fire_done    = 1'b0;
      command_data = 16'h0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // STP slot 2, degree 5
      send(16'h4500, 1'b0, 8'd0, 5'd5, 4'd5, 3'd2);
      finish_instr();
      // EVP on slot 2 looks up N=5
      send(16'h4301, 1'b0, 8'd1, 5'd3, 4'd5, 3'd2);
      finish_instr();
      // Rejected tokens keep previous decode
      send(16'hE402, 1'b1, 8'd1, 5'd3, 4'd5, 3'd2);  // EVB empty slot 7
      send(16'h0007, 1'b1, 8'd1, 5'd3, 4'd5, 3'd2);  // bad opcode
      send(16'h0001, 1'b1, 8'd1, 5'd3, 4'd5, 3'd2);  // EVP b=0
      // STP slot 5 degree 9
      send(16'hA900, 1'b0, 8'd0, 5'd9, 4'd9, 3'd5);
      finish_instr();
      // STP with b[4]=1 is rejected
      send(16'h3000, 1'b1, 8'd0, 5'd9, 4'd9, 3'd5);
      // EVB slot 5 b=1
      send(16'hA102, 1'b0, 8'd2, 5'd1, 4'd9, 3'd5);
      finish_instr();
      // RST command clears the table
      send(16'h0003, 1'b0, 8'd3, 5'd0, 4'd0, 3'd0);
      finish_instr();
      send(16'h4301, 1'b1, 8'd3, 5'd0, 4'd0, 3'd0);

      // Mid-instruction reset with coincident fire_done
      send(16'h4500, 1'b0, 8'd0, 5'd5, 4'd5, 3'd2);
      rst       = 1'b1;
      fire_done = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      fire_done = 1'b0;
      @(negedge clk);
      check_all_zero("mid_reset");
      @(posedge clk); #1;
      send(16'h4301, 1'b1, 8'd0, 5'd0, 4'd0, 3'd0);

      // Redefine slot 2, then EVP sees the new degree
      send(16'h4300, 1'b0, 8'd0, 5'd3, 4'd3, 3'd2);
      finish_instr();
      send(16'h4701, 1'b0, 8'd1, 5'd7, 4'd3, 3'd2);
      finish_instr();

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
      check("scoreboard_drained", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
